// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage valid/ready register pipeline with bubble collapsing.
//
// Entries enter at stage 0 and move one stage towards the output on every
// edge where the next stage can take them, so gaps in the pipeline close up
// even while the consumer is stalled. Output signals come straight from the
// last stage's registers, so there is no combinational path from in_* to
// out_*. in_ready does depend combinationally on out_ready.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-low reset
//   flush      drop every held entry at the next edge; blocks input
//   in_valid   producer offers in_data
//   in_ready   pipeline accepts in_data this cycle
//   in_data    entry payload, WIDTH bits
//   out_valid  out_data holds a valid entry (oldest held)
//   out_ready  consumer takes out_data this cycle
//   out_data   oldest held entry
//   count      number of valid entries held, 0..DEPTH
module pipe_reg #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [CntW-1:0]  count_q, count_d;

    // can_load[i]: stage i may take a new entry on this edge
    logic [DEPTH-1:0] can_load;
    logic             in_xfer;
    logic             out_xfer;

    // A stage can load if it, or any stage downstream of it, is empty, or if
    // the consumer drains the last stage. Walking from the output side keeps
    // this a simple OR chain without a self-referencing vector.
    always_comb begin : can_load_chain
        logic room;
        room = out_ready;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            room        = room | ~valid_q[i];
            can_load[i] = room;
        end
    end

    assign in_ready = reset & ~flush & can_load[0];
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = valid_q[DEPTH-1] & out_ready;

    // Each loading stage takes whatever its upstream neighbour holds (or the
    // input for stage 0). An empty upstream makes the stage empty; its data
    // register is left untouched so idle stages keep stale payloads.
    always_comb begin : next_state
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (can_load[i]) begin
                    if (i == 0) begin
                        valid_d[0] = in_xfer;
                        if (in_xfer) begin
                            data_d[0] = in_data;
                        end
                    end else begin
                        valid_d[i] = valid_q[i-1];
                        if (valid_q[i-1]) begin
                            data_d[i] = data_q[i-1];
                        end
                    end
                end
            end
        end
    end

    always_comb begin : count_next
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CntW'(in_xfer) - CntW'(out_xfer);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_reg.sv
// Bench for pipe_reg: three instances (DEPTH 2, 4 and 1, WIDTH 16) share the
// clock and reset. A position-tracking queue model per instance predicts the
// outputs; a negedge process compares every cycle, and the directed sequence
// adds hand-computed literal checks.
module tb_pipe_reg;

    logic clk = 1'b0;
    logic reset;
    logic [2:0] flush, in_valid, out_ready;
    logic [15:0] in_data [3];

    logic ov0, ov1, ov2, ir0, ir1, ir2;
    logic [15:0] od0, od1, od2;
    logic [1:0] cnt0;
    logic [2:0] cnt1;
    logic [0:0] cnt2;

    logic [2:0]  ov, ir;
    logic [15:0] od [3];
    int          cnt [3];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: per instance, held entries oldest-first with their stage index.
    int          m_cnt [3];
    int          m_pos [3][4];
    logic [15:0] m_dat [3][4];

    always #5 clk = ~clk;

    pipe_reg #(.WIDTH(16), .DEPTH(2)) u_d2 (
        .clk(clk), .reset(reset), .flush(flush[0]), .in_valid(in_valid[0]),
        .in_ready(ir0), .in_data(in_data[0]), .out_valid(ov0),
        .out_ready(out_ready[0]), .out_data(od0), .count(cnt0)
    );
    pipe_reg #(.WIDTH(16), .DEPTH(4)) u_d4 (
        .clk(clk), .reset(reset), .flush(flush[1]), .in_valid(in_valid[1]),
        .in_ready(ir1), .in_data(in_data[1]), .out_valid(ov1),
        .out_ready(out_ready[1]), .out_data(od1), .count(cnt1)
    );
    pipe_reg #(.WIDTH(16), .DEPTH(1)) u_d1 (
        .clk(clk), .reset(reset), .flush(flush[2]), .in_valid(in_valid[2]),
        .in_ready(ir2), .in_data(in_data[2]), .out_valid(ov2),
        .out_ready(out_ready[2]), .out_data(od2), .count(cnt2)
    );

    always_comb begin
        ov     = {ov2, ov1, ov0};
        ir     = {ir2, ir1, ir0};
        od[0]  = od0;
        od[1]  = od1;
        od[2]  = od2;
        cnt[0] = int'(cnt0);
        cnt[1] = int'(cnt1);
        cnt[2] = int'(cnt2);
    end

    function automatic int dep(input int k);
        case (k)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update: pop the head if taken, advance each entry as far as the
    // one ahead allows (head may reach the last stage), then append input.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int d, lim, np;
            bit acc, pop;
            d = dep(k);
            if (!reset || flush[k]) begin
                m_cnt[k] = 0;
            end else begin
                acc = in_valid[k] && (m_cnt[k] < d || out_ready[k]);
                pop = m_cnt[k] > 0 && m_pos[k][0] == d - 1 && out_ready[k];
                if (pop) begin
                    for (int j = 0; j < m_cnt[k] - 1; j++) begin
                        m_dat[k][j] = m_dat[k][j+1];
                        m_pos[k][j] = m_pos[k][j+1];
                    end
                    m_cnt[k]--;
                end
                lim = d - 1;
                for (int j = 0; j < m_cnt[k]; j++) begin
                    np = (m_pos[k][j] + 1 < lim) ? m_pos[k][j] + 1 : lim;
                    m_pos[k][j] = np;
                    lim = np - 1;
                end
                if (acc) begin
                    m_dat[k][m_cnt[k]] = in_data[k];
                    m_pos[k][m_cnt[k]] = 0;
                    m_cnt[k]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                bit exp_ov, exp_ir;
                exp_ov = m_cnt[k] > 0 && m_pos[k][0] == dep(k) - 1;
                exp_ir = reset && !flush[k] && (m_cnt[k] < dep(k) || out_ready[k]);
                chk($sformatf("d%0d out_valid", dep(k)), int'(ov[k]), int'(exp_ov));
                chk($sformatf("d%0d count", dep(k)), cnt[k], m_cnt[k]);
                chk($sformatf("d%0d in_ready", dep(k)), int'(ir[k]), int'(exp_ir));
                if (exp_ov) begin
                    chk($sformatf("d%0d out_data", dep(k)), int'(od[k]), int'(m_dat[k][0]));
                end
            end
        end
    end

    initial begin
        reset     = 1'b0;
        flush     = '0;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) in_data[k] = '0;
        for (int k = 0; k < 3; k++) m_cnt[k] = 0;
        step();
        chk_en = 1'b1;
        step();

        // Reset state
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst d%0d out_valid", dep(k)), int'(ov[k]), 0);
            chk($sformatf("rst d%0d out_data", dep(k)), int'(od[k]), 0);
            chk($sformatf("rst d%0d count", dep(k)), cnt[k], 0);
            chk($sformatf("rst d%0d in_ready", dep(k)), int'(ir[k]), 0);
        end
        reset = 1'b1;
        #1;
        chk("release in_ready", int'(ir), 7);

        // Single entry latency, DEPTH=2
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h1234;
        step();
        in_valid[0] = 1'b0;
        chk("lat e1 count", cnt[0], 1);
        chk("lat e1 out_valid", int'(ov0), 0);
        step();
        chk("lat e2 out_valid", int'(ov0), 1);
        chk("lat e2 out_data", int'(od0), 16'h1234);
        chk("lat e2 count", cnt[0], 1);
        step();
        chk("lat e3 count", cnt[0], 0);
        chk("lat e3 out_valid", int'(ov0), 0);

        // Backpressure: A, B accepted, C held until the consumer drains
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h000A;
        step();
        in_data[0] = 16'h000B;
        step();
        in_data[0] = 16'h000C;
        #1;
        chk("bp full in_ready", int'(ir0), 0);
        chk("bp full count", cnt[0], 2);
        step();
        chk("bp hold out_data", int'(od0), 16'h000A);
        chk("bp hold count", cnt[0], 2);
        out_ready[0] = 1'b1;
        #1;
        chk("bp drain in_ready", int'(ir0), 1);
        step();
        in_valid[0] = 1'b0;
        chk("bp out B", int'(od0), 16'h000B);
        step();
        chk("bp out C", int'(od0), 16'h000C);
        step();
        chk("bp empty", int'(ov0), 0);

        // Full-rate streaming with a full pipeline
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0100;
        step();
        in_data[0] = 16'h0101;
        step();
        out_ready[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data[0] = 16'(16'h0102 + i);
            #1;
            chk("stream out_valid", int'(ov0), 1);
            chk("stream out_data", int'(od0), 16'h0100 + i);
            chk("stream count", cnt[0], 2);
            step();
        end
        in_valid[0] = 1'b0;
        chk("stream tail", int'(od0), 16'h0108);
        repeat (3) step();

        // DEPTH=4 latency
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        in_data[1]   = 16'h4444;
        step();
        in_valid[1] = 1'b0;
        chk("d4 lat e1", int'(ov1), 0);
        step();
        chk("d4 lat e2", int'(ov1), 0);
        step();
        chk("d4 lat e3", int'(ov1), 0);
        step();
        chk("d4 lat e4 out_valid", int'(ov1), 1);
        chk("d4 lat e4 out_data", int'(od1), 16'h4444);
        step();
        chk("d4 lat e5", int'(ov1), 0);

        // Flush with three entries held and an input offered
        out_ready[1] = 1'b0;
        in_valid[1]  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data[1] = 16'(16'h0051 + i);
            step();
        end
        chk("flush pre count", cnt[1], 3);
        flush[1]   = 1'b1;
        in_data[1] = 16'hDEAD;
        #1;
        chk("flush in_ready", int'(ir1), 0);
        step();
        flush[1]    = 1'b0;
        in_valid[1] = 1'b0;
        chk("flush count", cnt[1], 0);
        chk("flush out_valid", int'(ov1), 0);
        out_ready[1] = 1'b1;
        repeat (5) step();
        chk("flush nothing out", int'(ov1), 0);

        // Reset mid-stream with two entries held
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'h0061;
        step();
        in_data[0] = 16'h0062;
        step();
        chk("midrst pre count", cnt[0], 2);
        out_ready[0] = 1'b1;
        in_data[0]   = 16'h0063;
        reset        = 1'b0;
        #1;
        chk("midrst in_ready", int'(ir0), 0);
        step();
        chk("midrst out_valid", int'(ov0), 0);
        chk("midrst out_data", int'(od0), 0);
        chk("midrst count", cnt[0], 0);
        reset       = 1'b1;
        in_valid[0] = 1'b0;
        #1;
        chk("midrst release in_ready", int'(ir0), 1);
        step();

        // Random traffic on all instances; only DEPTH 2/4 see flushes
        repeat (1000) begin
            for (int k = 0; k < 3; k++) begin
                in_valid[k]  = 1'($urandom_range(0, 1));
                out_ready[k] = 1'($urandom_range(0, 1));
                in_data[k]   = 16'($urandom);
                flush[k]     = (k != 2) && ($urandom_range(0, 31) == 0);
            end
            #1;
            chk("d1 count bound", int'(cnt[2] <= 1), 1);
            step();
        end
        flush     = '0;
        in_valid  = '0;
        out_ready = '1;
        repeat (6) step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("drain d%0d count", dep(k)), cnt[k], 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data bits per entry, minimum 1.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, minimum 1.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the block uses one clock only.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 SHALL have port flush  input  1  discards all held entries at the next edge.
REQ-006 SHALL have port in_valid  input  1  producer offers in_data.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  WIDTH  entry payload.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_data this cycle.
REQ-011 SHALL have port out_data  output  WIDTH  oldest held entry.
REQ-012 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries held.

Function
REQ-013 SHALL contain DEPTH stages, each with one WIDTH-bit data register and one valid bit; stage 0 is the input side and stage DEPTH-1 drives out_data/out_valid.
REQ-014 SHALL treat a transfer as occurring on an edge where valid and ready are both 1 on the same side.
REQ-015 SHALL let stage i load when it is empty, or when its entry moves to stage i+1 (or out, for the last stage) on the same edge.
REQ-016 SHALL collapse bubbles: an entry advances into any empty downstream stage every cycle.
REQ-017 SHALL drive in_ready = stage-0-can-load AND NOT flush; this is combinational from out_ready and the valid bits.
REQ-018 SHALL have out_valid and out_data come directly from last-stage registers, with no combinational path from in_* to out_*.
REQ-019 SHALL present an accepted entry on out_valid exactly DEPTH edges after acceptance when the pipeline is empty and out_ready stays 1.
REQ-020 SHALL sustain one transfer per cycle when in_valid and out_ready are held at 1.
REQ-021 SHALL hold a stage's data and valid bit unchanged while the stage is stalled.
REQ-022 SHALL keep out_data stable while out_valid=1 and out_ready=0.
REQ-023 SHALL preserve entry order; no entry is lost or duplicated.
REQ-024 SHALL update count as count + in_transfer − out_transfer on each edge; count=DEPTH means full (in_ready=0 unless out_ready=1); count=0 means empty (out_valid=0).
REQ-025 SHALL, when the block is full and out_ready=1 and in_valid=1 in the same cycle, perform both transfers, leaving count unchanged.
REQ-026 SHALL treat in_data as don't-care and leave data registers unloaded when in_valid=0; data registers of empty stages may keep stale values.
REQ-027 SHALL, when flush=1, clear all valid bits and count to 0 at the next edge; out_transfer that edge still counts as taken by the consumer; in_ready=0 so no input is accepted.

Reset
REQ-028 SHALL, on an edge with reset=0, clear all valid bits, all data registers and count to 0; out_valid=0 and out_data=0 afterwards.
REQ-029 SHALL give reset priority over flush and all transfers, including in mid-stream.
REQ-030 SHALL drive in_ready=0 while reset=0.
REQ-031 SHALL make in_ready=1 on the first cycle after reset release.

Verification
REQ-032 SHALL be checked with: DEPTH=2, WIDTH=16, out_ready=1, one entry 0x1234 -> out_valid=1 and out_data=0x1234 exactly 2 edges later, count 1 then 0.
REQ-033 SHALL be checked with: DEPTH=2, out_ready=0, push 0xA, 0xB, 0xC -> 0xA, 0xB accepted, count=2, in_ready=0, 0xC held; then out_ready=1 -> outputs 0xA, 0xB, 0xC in order.
REQ-034 SHALL be checked with: full pipeline plus in_valid=1, out_ready=1 for 8 cycles, incrementing data -> one output per cycle, count stays 2, no gaps.
REQ-035 SHALL be checked with: DEPTH=4, 3 entries held, flush=1 with in_valid=1 -> next cycle count=0, out_valid=0, the flush-cycle input is not accepted.
REQ-036 SHALL be checked with: reset=0 asserted mid-stream with count=2 -> next edge out_valid=0, out_data=0, count=0; after release in_ready=1.
REQ-037 SHALL be checked with: DEPTH=1, random in_valid/out_ready for 1000 cycles -> scoreboard matches in order, count never exceeds 1.
